// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and holds the
// returned word for decode. Define FETCH_MISALIGN_CHECK_EN to trap misaligned branch targets.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    input  logic            decode_ready,
    input  logic            pc_source,
    input  logic [XLEN-1:0] pc_target,
    output logic            fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [XLEN-1:0] NOP       = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MSK = ~{{(XLEN-2){1'b0}}, 2'b11};

    state_t          state;
    state_t          state_next;
    logic            load_pc;
    logic            load_instr;
    logic [XLEN-1:0] pc_next;

    assign pc_plus_4      = pc + XLEN'(4);
    assign imem_addr      = pc;
    assign imem_req_valid = (state == S_REQ);
    assign instr_valid    = (state == S_HOLD);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_fault = (state == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_pc    = 1'b0;
        load_instr = 1'b0;
        pc_next    = pc_plus_4;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (imem_req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    load_instr = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (decode_ready) begin
                    // Taken targets are word-aligned before use; with the check enabled a
                    // misaligned target traps instead and the PC is left untouched.
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (pc_source && (pc_target[1:0] != 2'b00)) begin
                        state_next = S_FAULT;
                    end else begin
                        load_pc    = 1'b1;
                        pc_next    = pc_source ? (pc_target & ALIGN_MSK) : pc_plus_4;
                        state_next = S_REQ;
                    end
`else
                    load_pc    = 1'b1;
                    pc_next    = pc_source ? (pc_target & ALIGN_MSK) : pc_plus_4;
                    state_next = S_REQ;
`endif
                end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= NOP;
        end else begin
            state <= state_next;
            if (load_pc)    pc    <= pc_next;
            if (load_instr) instr <= imem_rsp_data;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage placed directly upstream of the decoder/control unit.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Latches the returned instruction and presents it, with its PC and PC+4, to decode.
- Updates the PC when decode consumes the instruction, using the decoder's pc_source and the branch/jump target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width (only 32 supported)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address, word aligned
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  XLEN  returned instruction word
instr_valid  output  1  instr/pc outputs hold a valid instruction
instr  output  XLEN  latched instruction to decode (op=[6:0], func3=[14:12], func7=[31:25])
pc  output  XLEN  PC of instr
pc_plus_4  output  XLEN  pc + 4, mod 2^32
decode_ready  input  1  decode consumes instr this cycle (low = stall)
pc_source  input  1  from control: 1 = take pc_target
pc_target  input  XLEN  branch/jump target from the second adder
fetch_fault  output  1  misaligned-target fault (see Optional Feature; tied 0 when compiled out)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=S_IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req_valid=0, fetch_fault=0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT.
- S_IDLE: always advances to S_REQ next cycle. The first request is issued the second cycle after reset release.
- S_REQ:
  - imem_req_valid=1, imem_addr=pc.
  - imem_req_valid and imem_addr stay stable until imem_req_ready.
  - On imem_req_ready, go to S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid, register imem_rsp_data into instr and go to S_HOLD.
  - A zero-wait memory (ready and response on the same request cycle) is not supported: the response must come at least 1 cycle after acceptance.
- S_HOLD:
  - instr_valid=1; instr, pc and pc_plus_4 are stable.
  - While decode_ready=0, stay in S_HOLD (stall, no new request).
  - On decode_ready=1:
    - pc <= pc_source ? pc_target : pc_plus_4
    - instr_valid drops next cycle
    - go to S_REQ
- Next-PC rules:
  - pc_plus_4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
  - pc_source and pc_target are sampled only in S_HOLD with decode_ready=1; all other cycles ignore them.
- Unexpected responses: imem_rsp_valid outside S_WAIT is ignored, with no state change.
- Outstanding requests: at most one at any time.
- Throughput: best case one instruction per 3 cycles (REQ, WAIT, HOLD) with single-cycle ready and response.
- Reset mid-operation: all state returns to reset values immediately. Instruction memory shares rst and drops any in-flight response; the fetch unit makes no attempt to filter stale responses.
- S_FAULT: instr_valid=0, imem_req_valid=0, fetch_fault=1; held until reset.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - In S_HOLD with decode_ready=1, pc_source=1 and pc_target[1:0]!=0, the PC is not updated.
  - The FSM enters S_FAULT and fetch_fault goes high the next cycle.
  - The fall-through PC+4 path is never checked.
- Not defined:
  - pc_target[1:0] is forced to 2'b00 when loaded.
  - S_FAULT is unreachable and fetch_fault is tied 0.

Test Plan:
- Reset release, memory always ready, 1-cycle response:
  - Requests go to 0x0, 0x4, 0x8 while decode_ready is held 1.
  - Each instr word is presented with the matching pc; 3 cycles per instruction.
- Stall: hold decode_ready=0 for 5 cycles in S_HOLD with instr=0x00500093.
  - instr, pc and instr_valid stay stable; no imem_req_valid.
  - After decode_ready=1, the next request goes to pc+4.
- Branch taken: instr at 0x10 consumed with pc_source=1, pc_target=0x40.
  - Next imem_addr=0x40.
  - Repeat with pc_source=0: next imem_addr=0x14.
- Backpressure: imem_req_ready low 4 cycles.
  - imem_req_valid=1 and imem_addr are unchanged every cycle until accept.
  - A spurious imem_rsp_valid during S_REQ is ignored.
- Wrap and reset: RESET_PC=0xFFFF_FFFC.
  - After the first consume, next imem_addr=0x0.
  - Asserting rst while in S_WAIT returns outputs to reset values asynchronously, and the PC restarts at RESET_PC.
- Misaligned target, pc_target=0x42:
  - With FETCH_MISALIGN_CHECK_EN: fetch_fault=1, and no further requests.
  - Without it: next imem_addr=0x40.
